oc8051_fpga_btn: RTL and testbench

OC8051_FPGA_BTN -- requirements
Module: oc8051_fpga_btn

---
 rtl/oc8051_fpga_btn_pkg.sv | 19 +
 rtl/oc8051_fpga_btn_ch.sv | 76 +++++++
 rtl/oc8051_fpga_btn.sv | 67 ++++++
 tb/tb_oc8051_fpga_btn.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/oc8051_fpga_btn_pkg.sv
// rtl/oc8051_fpga_btn_pkg.sv - shared state encodings and defaults for the pushbutton front end
package oc8051_fpga_btn_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE       = 2'd0,
    BTN_PRESS_WAIT = 2'd1,
    BTN_PRESSED    = 2'd2,
    BTN_REL_WAIT   = 2'd3
  } btn_state_e;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int STRETCH_DEF    = 1024;
  localparam int CNT_W          = 16;

  function automatic logic [1:0] pop3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/oc8051_fpga_btn_ch.sv
// rtl/oc8051_fpga_btn_ch.sv - one pushbutton channel: 2-flop synchronizer plus debounce FSM
module oc8051_fpga_btn_ch
  import oc8051_fpga_btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic int_n,
  output logic int_pls
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic             smp;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  assign smp = sync[1];

  // int_n/int_pls are set on the same edge as the state transition so they stay registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= 2'b11;
      state   <= BTN_IDLE;
      cnt     <= '0;
      int_n   <= 1'b1;
      int_pls <= 1'b0;
    end else begin
      sync    <= {sync[0], btn_n};
      int_pls <= 1'b0;
      case (state)
        BTN_IDLE: begin
          if (!smp) begin
            state <= BTN_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        BTN_PRESS_WAIT: begin
          if (smp) begin
            state <= BTN_IDLE;
          end else if (cnt == DEB_LAST) begin
            state   <= BTN_PRESSED;
            int_n   <= 1'b0;
            int_pls <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BTN_PRESSED: begin
          if (smp) begin
            state <= BTN_REL_WAIT;
            cnt   <= '0;
          end
        end
        BTN_REL_WAIT: begin
          if (!smp) begin
            state <= BTN_PRESSED;
          end else if (cnt == DEB_LAST) begin
            state <= BTN_IDLE;
            int_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BTN_IDLE;
          int_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/oc8051_fpga_btn.sv
// rtl/oc8051_fpga_btn.sv - three debounced interrupt buttons with activity LED stretch and press counter
module oc8051_fpga_btn
  import oc8051_fpga_btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int STRETCH    = STRETCH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_n,
  output logic [2:0] int_n,
  output logic [2:0] int_pls,
  output logic       int_act,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);

  logic [CNT_W-1:0] stretch_cnt;
  logic             was_low;
  logic             any_low;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    oc8051_fpga_btn_ch #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n[g]),
      .int_n  (int_n[g]),
      .int_pls(int_pls[g])
    );
  end

  assign any_low = ~&int_n;

  // was_low marks the first all-released cycle so the stretch loads exactly once per release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_act     <= 1'b0;
      stretch_cnt <= '0;
      was_low     <= 1'b0;
    end else begin
      was_low <= any_low;
      if (any_low) begin
        int_act     <= 1'b1;
        stretch_cnt <= '0;
      end else if (was_low) begin
        int_act     <= 1'b1;
        stretch_cnt <= STRETCH_LAST;
      end else if (stretch_cnt != '0) begin
        stretch_cnt <= stretch_cnt - 1'b1;
      end else begin
        int_act <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_cnt <= '0;
    end else begin
      press_cnt <= press_cnt + {6'b0, pop3(int_pls)};
    end
  end

endmodule

// File: tb/tb_oc8051_fpga_btn.sv
// tb/tb_oc8051_fpga_btn.sv - self-checking bench for oc8051_fpga_btn with DEB_CYCLES=4, STRETCH=8
module tb_oc8051_fpga_btn;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn_n = 3'b111;
  logic [2:0] int_n;
  logic [2:0] int_pls;
  logic       int_act;
  logic [7:0] press_cnt;

  oc8051_fpga_btn #(
    .DEB_CYCLES(4),
    .STRETCH   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .int_n    (int_n),
    .int_pls  (int_pls),
    .int_act  (int_act),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int exp_cnt = 0;

  typedef struct {
    logic [2:0] mask;
    int         low_len;
    int         exp_fall;
    int         exp_rise;
    logic [2:0] exp_pls;
    int         exp_pcyc;
    int         exp_arise;
    int         exp_afall;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string name);
    int e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got %0d", name, press_cnt);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'b0, press_cnt}, e);
    end
  endtask

  // Edge k is the k-th rising edge after the raw low is applied.
  task automatic run_press(input logic [2:0] mask, input int len,
                           output int fall, output int rise, output logic [2:0] fall_val,
                           output logic [2:0] pls_or, output int pcyc,
                           output int arise, output int afall);
    fall = 0; rise = 0; fall_val = 3'b111; pls_or = 3'b000; pcyc = 0; arise = 0; afall = 0;
    for (int k = 1; k <= len + 25; k++) begin
      btn_n = (k <= len) ? ~mask : 3'b111;
      tick();
      if (fall == 0 && int_n != 3'b111) begin
        fall = k;
        fall_val = int_n;
      end
      if (fall != 0 && rise == 0 && int_n == 3'b111) rise = k;
      pls_or |= int_pls;
      if (int_pls != 3'b000) pcyc++;
      if (arise == 0 && int_act) arise = k;
      if (arise != 0 && afall == 0 && !int_act) afall = k;
    end
  endtask

  initial begin
    int fall, rise, pcyc, arise, afall, guard, hi_cnt, viol;
    logic [2:0] fall_val, pls_or, m;

    vecs[0] = '{3'b010, 100, 7, 107, 3'b010, 1, 8, 116};
    vecs[1] = '{3'b001,   3, 0,   0, 3'b000, 0, 0,   0};
    vecs[2] = '{3'b100,   4, 0,   0, 3'b000, 0, 0,   0};
    vecs[3] = '{3'b100,   5, 7,  12, 3'b100, 1, 8,  21};
    vecs[4] = '{3'b111,  10, 7,  17, 3'b111, 1, 8,  26};
    vecs[5] = '{3'b101,   6, 7,  13, 3'b101, 1, 8,  22};

    tick(); tick(); tick();
    check("reset int_n", {29'b0, int_n}, 3'b111);
    check("reset int_pls", {29'b0, int_pls}, 3'b000);
    check("reset int_act", {31'b0, int_act}, 0);
    check("reset press_cnt", {24'b0, press_cnt}, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].exp_pcyc != 0) exp_cnt = (exp_cnt + $countones(vecs[i].mask)) % 256;
      exp_q.push_back(exp_cnt);
      run_press(vecs[i].mask, vecs[i].low_len, fall, rise, fall_val, pls_or, pcyc, arise, afall);
      check($sformatf("vec%0d int_n fall edge", i), fall, vecs[i].exp_fall);
      check($sformatf("vec%0d int_n rise edge", i), rise, vecs[i].exp_rise);
      check($sformatf("vec%0d int_n low value", i), {29'b0, fall_val},
            (vecs[i].exp_fall != 0) ? {29'b0, ~vecs[i].mask} : 32'd7);
      check($sformatf("vec%0d pulse bits", i), {29'b0, pls_or}, {29'b0, vecs[i].exp_pls});
      check($sformatf("vec%0d pulse cycles", i), pcyc, vecs[i].exp_pcyc);
      check($sformatf("vec%0d int_act rise edge", i), arise, vecs[i].exp_arise);
      check($sformatf("vec%0d int_act fall edge", i), afall, vecs[i].exp_afall);
      sb_check($sformatf("vec%0d press_cnt", i));
    end

    guard = 0;
    while (exp_cnt != 254 && guard < 200) begin
      m = (254 - exp_cnt >= 3) ? 3'b111 : 3'b001;
      exp_cnt = (exp_cnt + $countones(m)) % 256;
      exp_q.push_back(exp_cnt);
      run_press(m, 5, fall, rise, fall_val, pls_or, pcyc, arise, afall);
      check("fill pulse cycles", pcyc, 1);
      sb_check("fill press_cnt");
      guard++;
    end
    check("fill reached 254", {24'b0, press_cnt}, 254);

    exp_cnt = (exp_cnt + 3) % 256;
    exp_q.push_back(exp_cnt);
    run_press(3'b111, 10, fall, rise, fall_val, pls_or, pcyc, arise, afall);
    check("all3 pulse bits", {29'b0, pls_or}, 3'b111);
    check("all3 pulse cycles", pcyc, 1);
    check("all3 fall edge", fall, 7);
    sb_check("all3 press_cnt wrap");

    btn_n = 3'b110;
    for (int k = 0; k < 4; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    check("async reset int_n", {29'b0, int_n}, 3'b111);
    check("async reset int_pls", {29'b0, int_pls}, 0);
    check("async reset press_cnt", {24'b0, press_cnt}, 0);
    exp_q.delete();
    exp_cnt = 0;
    tick(); tick();
    rst = 1'b1;
    exp_cnt = 1;
    exp_q.push_back(exp_cnt);
    fall = 0; pcyc = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (fall == 0 && int_n != 3'b111) fall = k;
      if (int_pls != 3'b000) pcyc++;
    end
    check("held after reset fall edge", fall, 7);
    check("held after reset pulses", pcyc, 1);
    sb_check("held after reset press_cnt");

    btn_n = 3'b111;
    for (int k = 1; k <= 10; k++) tick();
    check("mid stretch int_act", {31'b0, int_act}, 1);
    #2;
    rst = 1'b0;
    #1;
    check("stretch reset int_act", {31'b0, int_act}, 0);
    exp_q.delete();
    exp_cnt = 0;
    tick(); tick();
    rst = 1'b1;
    hi_cnt = 0; pcyc = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (int_act) hi_cnt++;
      if (int_pls != 3'b000) pcyc++;
    end
    check("stretch discarded", hi_cnt, 0);
    check("stretch reset no pulse", pcyc, 0);
    check("stretch reset press_cnt", {24'b0, press_cnt}, 0);

    exp_cnt = 1;
    exp_q.push_back(exp_cnt);
    btn_n = 3'b011;
    for (int k = 0; k < 10; k++) tick();
    check("bounce pressed int_n", {29'b0, int_n}, 3'b011);
    rise = 0; pcyc = 0;
    for (int k = 1; k <= 25; k++) begin
      btn_n = (k == 3) ? 3'b011 : 3'b111;
      tick();
      if (rise == 0 && int_n == 3'b111) rise = k;
      if (int_pls != 3'b000) pcyc++;
    end
    check("bounce release rise edge", rise, 10);
    check("bounce no extra pulse", pcyc, 0);
    sb_check("bounce press_cnt");

    exp_cnt = 3;
    exp_q.push_back(exp_cnt);
    fall = 0; afall = 0; viol = 0;
    for (int k = 1; k <= 50; k++) begin
      m = 3'b111;
      if (k <= 5) m[0] = 1'b0;
      if (k >= 12 && k <= 21) m[1] = 1'b0;
      btn_n = m;
      tick();
      if (fall == 0 && int_n[1] == 1'b0) fall = k;
      if (k >= 8 && afall == 0 && !int_act) afall = k;
      if (k >= 8 && k < 37 && !int_act) viol++;
    end
    check("abort second press fall edge", fall, 18);
    check("abort int_act held", viol, 0);
    check("abort int_act fall edge", afall, 37);
    sb_check("abort press_cnt");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
